// File: rtl/alu_mul_pkg.sv
// -----------------------------------------------------------------------------
// alu_mul_pkg
// Shared definitions for the multiplier-sharing scheduler in the ALU mainframe.
//   - Default operand/product widths, watchdog limit and counter width.
//   - Requester id type (two requesters -> one bit).
//   - Scheduler state encoding.
//   - Small helper to turn a requester id into its accept bit.
// -----------------------------------------------------------------------------
package alu_mul_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_PWIDTH  = 67;
  localparam int MUL_TIMEOUT = 64;
  localparam int MUL_CNTW    = 16;
  localparam int REQ_IDW     = 1;

  typedef logic [REQ_IDW-1:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } mul_state_e;

  // One-hot accept vector for a granted requester.
  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    logic [1:0] hot;
    if (id == 1'b1) begin
      hot = 2'b10;
    end else begin
      hot = 2'b01;
    end
    return hot;
  endfunction

endpackage : alu_mul_pkg

// File: rtl/mul_share_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and the priority pointer; the pointer only moves when the grant is
// actually consumed (take_i), and then points away from the winner so the
// other side is preferred on the next contested cycle.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset (pointer -> requester 0)
//   req_i[1:0]   request vector
//   take_i       the owner consumes the current grant this cycle
//   gnt_valid_o  at least one request is present
//   gnt_id_o     winning requester
// -----------------------------------------------------------------------------
module rr_arb2
  import alu_mul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_valid_o,
  output req_id_t    gnt_id_o
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  // Grant selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = 1'b0;
    case (req_i)
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = 1'b0;
      end
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = 1'b1;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = ptr_q;
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = 1'b0;
      end
    endcase
  end

  // Pointer next state: after a consumed grant prefer the loser.
  always_comb begin
    ptr_d = ptr_q;
    if (take_i && gnt_valid_o) begin
      ptr_d = ~gnt_id_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2

// File: rtl/mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// mul_share_ctrl
// Scheduler that shares one multi-cycle signed 32x32 multiplier between two
// requesters. It arbitrates round-robin, captures the winner's operands,
// drives the multiplier start/done handshake, skips the multiplier entirely
// when an operand is zero, aborts an operation that overstays the watchdog,
// and returns exactly one tagged result per operation on a valid/ready port.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req[1:0]                 request per requester; operands held until accept
//   x0/y0, x1/y1             signed operands of requester 0 / 1
//   accept[1:0]              one-cycle pulse: operands of requester i captured
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester that owns the response
//   rsp_product              PWIDTH-bit product (0 on zero-skip or timeout)
//   rsp_timeout              response is an aborted operation
//   mul_x/mul_y              operands to the multiplier (captured operands)
//   mul_start                level start to the multiplier (ISSUE and BUSY)
//   mul_done/mul_product     multiplier completion and result
//   busy                     scheduler not idle
//   ops_done                 completed responses (wrapping)
// -----------------------------------------------------------------------------
module mul_share_ctrl
  import alu_mul_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int PWIDTH  = MUL_PWIDTH,
  parameter int TIMEOUT = MUL_TIMEOUT,
  parameter int CNTW    = MUL_CNTW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [WIDTH-1:0]  x0,
  input  logic [WIDTH-1:0]  y0,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  y1,
  output logic [1:0]        accept,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [PWIDTH-1:0] rsp_product,
  output logic              rsp_timeout,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  mul_x,
  output logic [WIDTH-1:0]  mul_y,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [PWIDTH-1:0] mul_product,
  output logic              busy,
  output logic [CNTW-1:0]   ops_done
);

  // Watchdog counts BUSY cycles 0 .. TIMEOUT-1.
  localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   T_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]   T_ZERO  = {TW{1'b0}};
  localparam logic [CNTW-1:0] C_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
  localparam logic [PWIDTH-1:0] P_ZERO = {PWIDTH{1'b0}};

  mul_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [WIDTH-1:0]  op_x_q, op_x_d;
  logic [WIDTH-1:0]  op_y_q, op_y_d;
  logic [1:0]        accept_q, accept_d;
  logic              rsp_valid_q, rsp_valid_d;
  req_id_t           rsp_id_q, rsp_id_d;
  logic [PWIDTH-1:0] rsp_product_q, rsp_product_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              mul_start_q, mul_start_d;
  logic              busy_q, busy_d;
  logic [CNTW-1:0]   ops_q, ops_d;

  logic              arb_take_s;
  logic              arb_valid_s;
  req_id_t           arb_id_s;
  logic [WIDTH-1:0]  sel_x_s;
  logic [WIDTH-1:0]  sel_y_s;
  logic              sel_zero_s;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .take_i      (arb_take_s),
    .gnt_valid_o (arb_valid_s),
    .gnt_id_o    (arb_id_s)
  );

  // Operands of the current arbitration winner and the zero-skip test.
  always_comb begin
    if (arb_id_s == 1'b1) begin
      sel_x_s = x1;
      sel_y_s = y1;
    end else begin
      sel_x_s = x0;
      sel_y_s = y0;
    end
    sel_zero_s = (sel_x_s == W_ZERO) || (sel_y_s == W_ZERO);
  end

  // Scheduler next state, watchdog, response register and output decode.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    op_x_d        = op_x_q;
    op_y_d        = op_y_q;
    accept_d      = 2'b00;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    rsp_timeout_d = rsp_timeout_q;
    ops_d         = ops_q;
    arb_take_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          arb_take_s    = 1'b1;
          op_x_d        = sel_x_s;
          op_y_d        = sel_y_s;
          accept_d      = id_to_onehot(arb_id_s);
          rsp_id_d      = arb_id_s;
          // Zero-skip result is preloaded; the ISSUE path overwrites it.
          rsp_product_d = P_ZERO;
          rsp_timeout_d = 1'b0;
          if (sel_zero_s) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        timer_d = T_ZERO;
        state_d = ST_BUSY;
      end

      ST_BUSY: begin
        // Completion is checked first so done beats a simultaneous timeout.
        if (mul_done) begin
          rsp_product_d = mul_product;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (timer_q == T_LAST) begin
          rsp_product_d = P_ZERO;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          timer_d = timer_q + T_ONE;
          state_d = ST_BUSY;
        end
      end

      ST_RESP: begin
        // rsp_valid is high throughout RESP, so rsp_ready alone completes it.
        if (rsp_ready) begin
          ops_d   = ops_q + C_ONE;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state.
    mul_start_d = (state_d == ST_ISSUE) || (state_d == ST_BUSY);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= T_ZERO;
      op_x_q        <= W_ZERO;
      op_y_q        <= W_ZERO;
      accept_q      <= 2'b00;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= P_ZERO;
      rsp_timeout_q <= 1'b0;
      mul_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      ops_q         <= {CNTW{1'b0}};
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op_x_q        <= op_x_d;
      op_y_q        <= op_y_d;
      accept_q      <= accept_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_timeout_q <= rsp_timeout_d;
      mul_start_q   <= mul_start_d;
      busy_q        <= busy_d;
      ops_q         <= ops_d;
    end
  end

  assign accept      = accept_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign rsp_timeout = rsp_timeout_q;
  assign mul_x       = op_x_q;
  assign mul_y       = op_y_q;
  assign mul_start   = mul_start_q;
  assign busy        = busy_q;
  assign ops_done    = ops_q;

endmodule : mul_share_ctrl

// File: tb/tb_mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_share_ctrl
// Directed scenarios followed by random traffic. Two requester queues feed
// the DUT; a multiplier model answers after a per-operation delay (or never).
// The reference is transaction level: each accepted operation yields one
// expected response computed from the operands and the delay.
// -----------------------------------------------------------------------------
module tb_mul_share_ctrl;

  localparam int WIDTH  = 32;
  localparam int PWIDTH = 67;
  localparam int CNTW   = 16;
  localparam int MAXD   = 65;  // latest start-relative cycle a done still counts

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [WIDTH-1:0]  x0, y0, x1, y1;
  logic [1:0]        accept;
  logic              rsp_valid, rsp_id, rsp_timeout, rsp_ready;
  logic [PWIDTH-1:0] rsp_product, mul_product;
  logic [WIDTH-1:0]  mul_x, mul_y;
  logic              mul_start, mul_done, busy;
  logic [CNTW-1:0]   ops_done;

  always #5 clk = ~clk;

  mul_share_ctrl #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .TIMEOUT(64), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .accept(accept), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready),
    .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start),
    .mul_done(mul_done), .mul_product(mul_product),
    .busy(busy), .ops_done(ops_done)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          d;   // multiplier delay in start-high cycles, 0 = never
  } op_t;

  op_t q0[$];
  op_t q1[$];

  int          n_vec = 0;
  int          n_miss = 0;
  logic        in_flight;
  op_t         cur;
  logic        cur_id, cur_zero, cur_to;
  logic [66:0] cur_prod;
  int          cur_start_cycles;
  int          cnt;
  logic        fell;
  logic        last_served;
  logic [15:0] exp_ops;
  int          bp_left;
  logic [1:0]  drop;

  task automatic check_val(input string tag, input logic [66:0] act, input logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [66:0] mult(input logic [31:0] a, input logic [31:0] b);
    longint la, lb, p;
    la = $signed(a);
    lb = $signed(b);
    p  = la * lb;
    return {{3{p[63]}}, p};
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 300));
      2: return -32'($urandom_range(1, 300));
      default: return $urandom();
    endcase
  endfunction

  task automatic push(input int r, input logic [31:0] x, input logic [31:0] y, input int d);
    op_t o;
    o.x = x; o.y = y; o.d = d;
    if (r == 0) q0.push_back(o);
    else        q1.push_back(o);
  endtask

  task automatic reset_model();
    q0.delete(); q1.delete();
    in_flight = 1'b0; last_served = 1'b1; exp_ops = 16'd0;
    cnt = 0; fell = 1'b0; bp_left = 0; drop = 2'b00;
    req = 2'b00; x0 = 32'd0; y0 = 32'd0; x1 = 32'd0; y1 = 32'd0;
    mul_done = 1'b0; mul_product = 67'd0; rsp_ready = 1'b0;
  endtask

  // One clock cycle: sample and check at the falling edge, then drive.
  task automatic step();
    logic [1:0] pend;
    logic       w, ok;
    @(negedge clk);
    mul_done = 1'b0;
    check_val("ops_done", ops_done, exp_ops);

    if (accept != 2'b00) begin
      check_val("accept_in_flight", in_flight, 1'b0);
      pend = req;
      if (pend == 2'b00) begin
        check_val("accept_spurious", accept, 2'b00);
      end else begin
        w = (pend == 2'b11) ? ~last_served : pend[1];
        check_val("accept", accept, w ? 2'b10 : 2'b01);
        if (w) cur = q1.pop_front();
        else   cur = q0.pop_front();
        cur_id      = w;
        last_served = w;
        in_flight   = 1'b1;
        cur_zero    = (cur.x == 32'd0) || (cur.y == 32'd0);
        ok          = !cur_zero && cur.d >= 2 && cur.d <= MAXD;
        cur_to      = !cur_zero && !ok;
        cur_prod    = ok ? mult(cur.x, cur.y) : 67'd0;
        cur_start_cycles = ok ? cur.d : MAXD;
        cnt = 0; fell = 1'b0;
        req[w] = 1'b0; drop[w] = 1'b1;
        if (cur_zero) check_val("zs_latency", rsp_valid, 1'b1);
      end
    end

    check_val("busy", busy, in_flight);
    if (!in_flight) begin
      check_val("start_idle", mul_start, 1'b0);
      check_val("rsp_idle", rsp_valid, 1'b0);
    end else if (cur_zero) begin
      check_val("zs_no_start", mul_start, 1'b0);
    end else if (mul_start) begin
      cnt++;
      check_val("mul_x", mul_x, cur.x);
      check_val("mul_y", mul_y, cur.y);
      if (!cur_to && cnt == cur.d) begin
        mul_done = 1'b1;
        mul_product = cur_prod;
      end
    end else if (cnt > 0 && !fell) begin
      fell = 1'b1;
      check_val("start_cycles", cnt, cur_start_cycles);
      check_val("rsp_after_mul", rsp_valid, 1'b1);
      if (cur_to) begin
        // Late completion after the abort must be ignored.
        mul_done = 1'b1;
        mul_product = 67'h5_A5A5_A5A5_A5A5_A5A5;
      end
    end

    if (in_flight && rsp_valid) begin
      check_val("rsp_id", rsp_id, cur_id);
      check_val("rsp_product", rsp_product, cur_prod);
      check_val("rsp_timeout", rsp_timeout, cur_to);
      if (bp_left > 0) begin
        rsp_ready = 1'b0;
        bp_left--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_ready) begin
        exp_ops++;
        in_flight = 1'b0;
      end
    end else begin
      rsp_ready = 1'($urandom_range(0, 1));
    end

    if (!drop[0] && !req[0] && q0.size() > 0) begin
      req[0] = 1'b1; x0 = q0[0].x; y0 = q0[0].y;
    end
    if (!drop[1] && !req[1] && q1.size() > 0) begin
      req[1] = 1'b1; x1 = q1[0].x; y1 = q1[0].y;
    end
    drop = 2'b00;
  endtask

  task automatic drain(input int budget);
    int   n;
    logic pend_s;
    n = 0;
    while ((in_flight || q0.size() > 0 || q1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    pend_s = in_flight || (q0.size() != 0) || (q1.size() != 0);
    check_val("drain", pend_s, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    check_val("rst_accept", accept, 2'b00);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_mul_start", mul_start, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ops", ops_done, 16'd0);
    check_val("rst_mul_x", mul_x, 32'd0);
    check_val("rst_product", rsp_product, 67'd0);
    rst = 1'b0;
    step();

    // Simultaneous pairs: order must alternate 0,1,0,1.
    push(0, 32'd5, 32'd6, 3);
    push(1, 32'd7, 32'd8, 4);
    push(0, -32'sd9, 32'd10, 5);
    push(1, 32'd11, -32'sd12, 2);
    drain(1000);

    push(0, 32'd172, 32'd172, 26);             drain(500);
    push(0, 32'hFFFF_FFFD, 32'd7, 10);         drain(500);
    push(1, 32'd0, 32'd12345, 5);              drain(500);
    push(0, 32'd1, 32'd1, 0);                  drain(500);  // never done
    push(1, 32'h8000_0000, 32'h8000_0000, 65); drain(500);  // done on last cycle
    push(0, 32'd3, 32'd3, 66);                 drain(500);  // done too late
    push(1, 32'd9, 32'd9, 2);                  drain(500);

    // Backpressure with a second requester waiting.
    bp_left = 5;
    push(0, 32'd3, 32'd4, 6);
    push(1, 32'h7FFF_FFFF, 32'd2, 8);
    drain(500);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 5) == 0)
        push(0, rand_opnd(), rand_opnd(), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 70)));
      if (q1.size() < 2 && $urandom_range(0, 5) == 0)
        push(1, rand_opnd(), rand_opnd(), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 70)));
      if ($urandom_range(0, 60) == 0) bp_left = int'($urandom_range(1, 6));
      step();
    end
    drain(3000);

    // Reset in the middle of BUSY.
    push(0, 32'd21, 32'd2, 0);
    n = 0;
    while (!(in_flight && cnt >= 5) && n < 200) begin
      step();
      n++;
    end
    check_val("rst_setup_busy", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_mul_start", mul_start, 1'b0);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check_val("mid_rst_ops", ops_done, 16'd0);
    check_val("mid_rst_mul_x", mul_x, 32'd0);
    @(negedge clk);
    reset_model();
    rst = 1'b0;
    mul_done = 1'b1;  // stray completion while idle
    mul_product = 67'd77;
    repeat (3) step();

    // Pointer is back at requester 0 after reset.
    push(1, 32'd4, 32'd5, 3);
    push(0, 32'd6, 32'd7, 3);
    drain(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mul_share_ctrl
